// File: rtl/pitch_pkg.sv
// pitch_pkg: shared FSM states, phase fixed-point helpers and Hz scaling constants
// for the phase-vocoder pitch estimator.
package pitch_pkg;

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT_BIN,
        S_READ,
        S_DELTA,
        S_SCALE,
        S_SUM,
        S_OUT
    } state_t;

    localparam int PHASE_INT_BITS = 3;

    function automatic int phase_frac(input int phase_w);
        return phase_w - PHASE_INT_BITS;
    endfunction

    // Q.10 Hz per FFT bin, rounded
    function automatic longint bin_hz_calc(input longint fs, input longint fft_n);
        return (fs * 1024 + fft_n / 2) / fft_n;
    endfunction

    // Q.10 Hz per unit (pi rad) of phase deviation over one hop, rounded
    function automatic longint corr_hz_calc(input longint fs, input longint hop);
        return (fs * 1024 + hop) / (2 * hop);
    endfunction

endpackage

// File: rtl/phase_pingpong_ram.sv
// phase_pingpong_ram: two phase banks sharing one write port (bank select) and a
// registered read of both banks at the same address.
module phase_pingpong_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wsel,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata0,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] bank0 [DEPTH];
    logic [W-1:0] bank1 [DEPTH];

    always_ff @(posedge clk) begin
        if (we && !wsel) bank0[waddr] <= wdata;
        if (we && wsel) bank1[waddr] <= wdata;
        if (re) begin
            rdata0 <= bank0[raddr];
            rdata1 <= bank1[raddr];
        end
    end

endmodule

// File: rtl/phase_vocoder_pitch.sv
// phase_vocoder_pitch: refines the fundamental-bin frequency from the wrapped
// frame-to-frame phase advance and emits it on a backpressured stream.
module phase_vocoder_pitch
    import pitch_pkg::*;
#(
    parameter int FFT_N    = 1024,
    parameter int HOP      = 1024,
    parameter int FS       = 48000,
    parameter int NUM_BINS = 32,
    parameter int PHASE_W  = 24,
    parameter int OUT_W    = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PHASE_W-1:0]          phase_data,
    input  logic                        phase_valid,
    output logic                        phase_ready,
    input  logic                        phase_last,
    input  logic [$clog2(NUM_BINS):0]   fbin_data,
    input  logic                        fbin_valid,
    output logic                        fbin_ready,
    output logic [OUT_W-1:0]            pitch_data,
    output logic                        pitch_valid,
    input  logic                        pitch_ready,
    output logic                        frame_err,
    output logic                        bin_err
);

    localparam int AW   = $clog2(NUM_BINS);
    localparam int KW   = AW + 1;
    localparam int BW   = $clog2(FFT_N);
    localparam int HB   = $clog2(HOP);
    localparam int FRAC = phase_frac(PHASE_W);
    localparam int EW   = KW + PHASE_W + HB;
    localparam int HW   = KW + 32;
    localparam int CW   = PHASE_W + 33;
    localparam int SW   = HW + CW;
    localparam logic [31:0]        BIN_HZ_C  = 32'(bin_hz_calc(FS, FFT_N));
    localparam logic signed [32:0] CORR_HZ_C = 33'(corr_hz_calc(FS, HOP));
    localparam logic [BW-1:0]      B_LAST    = BW'(FFT_N - 1);
    localparam logic [SW-1:0]      OUT_MAX   = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    state_t                   state_q, state_d;
    logic [BW-1:0]            b_q, b_d;
    logic                     sel_q, sel_d;
    logic                     first_q, first_d;
    logic                     held_q, held_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [PHASE_W-1:0] dev_q, dev_d;
    logic [HW-1:0]            bin_hz_q, bin_hz_d;
    logic signed [CW-1:0]     corr_q, corr_d;
    logic [OUT_W-1:0]         pitch_q, pitch_d;
    logic                     frame_err_q, frame_err_d;
    logic                     bin_err_q, bin_err_d;

    logic                     we, re, p_hs, f_hs, in_range;
    logic [PHASE_W-1:0]       rdata0, rdata1, cur, last, t;
    logic [EW-1:0]            e_full;
    logic signed [SW-1:0]     f_full;

    phase_pingpong_ram #(.DEPTH(NUM_BINS), .W(PHASE_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .wsel  (sel_q),
        .waddr (b_q[AW-1:0]),
        .wdata (phase_data),
        .re    (re),
        .raddr (k_q[AW-1:0]),
        .rdata0(rdata0),
        .rdata1(rdata1)
    );

    assign phase_ready = !reset && state_q == S_FILL;
    assign fbin_ready  = !reset && !held_q && (state_q == S_FILL || state_q == S_WAIT_BIN);
    assign pitch_valid = !reset && state_q == S_OUT;
    assign pitch_data  = pitch_q;
    assign frame_err   = frame_err_q;
    assign bin_err     = bin_err_q;

    assign p_hs     = phase_valid && phase_ready;
    assign f_hs     = fbin_valid && fbin_ready;
    assign in_range = {1'b0, b_q} < (BW+1)'(NUM_BINS);
    assign cur      = sel_q ? rdata1 : rdata0;
    assign last     = sel_q ? rdata0 : rdata1;
    // expected advance k*2*HOP/FFT_N in pi units; the mod 2 falls out of the wrap below
    assign e_full   = (EW'(k_q) << (PHASE_W - 2 + HB)) >> BW;
    assign t        = cur - last - PHASE_W'(e_full);
    assign f_full   = SW'($signed({1'b0, bin_hz_q})) + SW'(corr_q);

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        sel_d       = sel_q;
        first_d     = first_q;
        held_d      = held_q;
        k_d         = k_q;
        dev_d       = dev_q;
        bin_hz_d    = bin_hz_q;
        corr_d      = corr_q;
        pitch_d     = pitch_q;
        frame_err_d = 1'b0;
        bin_err_d   = 1'b0;
        we          = 1'b0;
        re          = 1'b0;
        if (f_hs) begin
            held_d = 1'b1;
            k_d    = fbin_data;
        end
        case (state_q)
            S_FILL: if (p_hs) begin
                we = in_range;
                if (phase_last && b_q == B_LAST) begin
                    b_d     = '0;
                    state_d = (held_q || f_hs) ? S_READ : S_WAIT_BIN;
                end else if (phase_last || b_q == B_LAST) begin
                    frame_err_d = 1'b1;
                    b_d         = '0;
                    held_d      = 1'b0;
                    first_d     = 1'b1;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            S_WAIT_BIN: state_d = f_hs ? S_READ : S_WAIT_BIN;
            S_READ: begin
                if (first_q || k_q >= KW'(NUM_BINS)) begin
                    first_d   = 1'b0;
                    bin_err_d = !first_q;
                    sel_d     = !sel_q;
                    held_d    = 1'b0;
                    state_d   = S_FILL;
                end else begin
                    re      = 1'b1;
                    state_d = S_DELTA;
                end
            end
            S_DELTA: begin
                // keep PHASE_W-2 LSBs and sign-extend: wraps into [-1,1)
                dev_d   = $signed(t << 2) >>> 2;
                state_d = S_SCALE;
            end
            S_SCALE: begin
                bin_hz_d = HW'(k_q) * HW'(BIN_HZ_C);
                corr_d   = (CW'(dev_q) * CW'(CORR_HZ_C)) >>> FRAC;
                state_d  = S_SUM;
            end
            S_SUM: begin
                pitch_d = f_full < 0 ? '0 : f_full > $signed(OUT_MAX) ? '1 : f_full[OUT_W-1:0];
                state_d = S_OUT;
            end
            S_OUT: if (pitch_ready) begin
                sel_d   = !sel_q;
                b_d     = '0;
                held_d  = 1'b0;
                state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FILL;
            b_q         <= '0;
            sel_q       <= 1'b0;
            first_q     <= 1'b1;
            held_q      <= 1'b0;
            k_q         <= '0;
            dev_q       <= '0;
            bin_hz_q    <= '0;
            corr_q      <= '0;
            pitch_q     <= '0;
            frame_err_q <= 1'b0;
            bin_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            first_q     <= first_d;
            held_q      <= held_d;
            k_q         <= k_d;
            dev_q       <= dev_d;
            bin_hz_q    <= bin_hz_d;
            corr_q      <= corr_d;
            pitch_q     <= pitch_d;
            frame_err_q <= frame_err_d;
            bin_err_q   <= bin_err_d;
        end
    end

endmodule

// File: tb/tb_phase_vocoder_pitch.sv
// tb_phase_vocoder_pitch: directed frames with hand-computed pitch values for the
// default 1024-point, 48 kHz configuration.
module tb_phase_vocoder_pitch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] phase_data = '0;
    logic        phase_valid = 1'b0;
    logic        phase_ready;
    logic        phase_last = 1'b0;
    logic [5:0]  fbin_data = '0;
    logic        fbin_valid = 1'b0;
    logic        fbin_ready;
    logic [23:0] pitch_data;
    logic        pitch_valid;
    logic        pitch_ready = 1'b1;
    logic        frame_err;
    logic        bin_err;

    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    int          n_ferr = 0;
    int          n_berr = 0;
    logic [23:0] last_pitch = '0;
    logic [23:0] held_pitch;

    phase_vocoder_pitch dut (
        .clk        (clk),
        .reset      (reset),
        .phase_data (phase_data),
        .phase_valid(phase_valid),
        .phase_ready(phase_ready),
        .phase_last (phase_last),
        .fbin_data  (fbin_data),
        .fbin_valid (fbin_valid),
        .fbin_ready (fbin_ready),
        .pitch_data (pitch_data),
        .pitch_valid(pitch_valid),
        .pitch_ready(pitch_ready),
        .frame_err  (frame_err),
        .bin_err    (bin_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pitch_valid && pitch_ready) begin
            n_out      <= n_out + 1;
            last_pitch <= pitch_data;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (bin_err) n_berr <= n_berr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_fbin(input int k);
        int t = 0;
        fbin_data  = 6'(k);
        fbin_valid = 1'b1;
        @(negedge clk);
        while (!fbin_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!fbin_ready) check("fbin_hs", 32'(fbin_ready), 1);
        @(posedge clk);
        #1 fbin_valid = 1'b0;
    endtask

    // bin 10 carries ph; other bins carry filler that must not affect the result
    task automatic send_frame(input logic [23:0] ph, input int last_at);
        for (int i = 0; i <= last_at; i++) begin
            int t = 0;
            phase_valid = 1'b1;
            phase_data  = (i == 10) ? ph : 24'(i * 37);
            phase_last  = (i == last_at);
            @(negedge clk);
            while (!phase_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!phase_ready) check("phase_hs", 32'(phase_ready), 1);
            @(posedge clk);
            #1;
        end
        phase_valid = 1'b0;
        phase_last  = 1'b0;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        @(negedge clk);
        while (!pitch_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(pitch_valid), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pitch_valid", 32'(pitch_valid), 0);
        check("rst_pitch_data", 32'(pitch_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_bin_err", 32'(bin_err), 0);
        check("rst_phase_ready", 32'(phase_ready), 0);
        check("rst_fbin_ready", 32'(fbin_ready), 0);
        reset = 1'b0;
        #1;
        check("post_rst_phase_ready", 32'(phase_ready), 1);
        check("post_rst_fbin_ready", 32'(fbin_ready), 1);

        send_fbin(10);
        send_frame(24'h000000, 1023);
        settle();
        check("first_frame_no_out", 32'(n_out), 0);
        send_fbin(10);
        send_frame(24'h000000, 1023);
        settle();
        check("zero_adv_count", 32'(n_out), 1);
        check("zero_adv_pitch", 32'(last_pitch), 32'h075300);

        send_fbin(10);
        send_frame(24'h100000, 1023);
        settle();
        check("half_pi_count", 32'(n_out), 2);
        check("half_pi_pitch", 32'(last_pitch), 32'h0781E0);

        send_fbin(10);
        send_frame(24'h1C0000, 1023);
        settle();
        check("pos_375_pitch", 32'(last_pitch), 32'h077628);
        send_fbin(10);
        send_frame(24'hE40000, 1023);
        settle();
        check("wrap_count", 32'(n_out), 4);
        check("wrap_pitch", 32'(last_pitch), 32'h076A70);

        send_fbin(40);
        send_frame(24'h000000, 1023);
        settle();
        check("bin_err_count", 32'(n_berr), 1);
        check("bin_err_no_out", 32'(n_out), 4);
        send_fbin(10);
        send_frame(24'h100000, 1023);
        settle();
        check("after_bin_err_count", 32'(n_out), 5);
        check("after_bin_err_pitch", 32'(last_pitch), 32'h0781E0);
        check("bin_err_once", 32'(n_berr), 1);

        send_fbin(10);
        send_frame(24'h000000, 500);
        settle();
        check("frame_err_count", 32'(n_ferr), 1);
        check("frame_err_no_out", 32'(n_out), 5);
        send_fbin(10);
        send_frame(24'h000000, 1023);
        settle();
        check("after_frame_err_first", 32'(n_out), 5);
        send_fbin(10);
        send_frame(24'h000000, 1023);
        settle();
        check("after_frame_err_count", 32'(n_out), 6);
        check("after_frame_err_pitch", 32'(last_pitch), 32'h075300);
        check("frame_err_once", 32'(n_ferr), 1);

        pitch_ready = 1'b0;
        send_fbin(10);
        send_frame(24'h100000, 1023);
        wait_valid("bp_valid");
        held_pitch = pitch_data;
        check("bp_pitch", 32'(held_pitch), 32'h0781E0);
        repeat (10) begin
            @(negedge clk);
            check("bp_stable", 32'(pitch_data), 32'(held_pitch));
            check("bp_phase_ready", 32'(phase_ready), 0);
        end
        pitch_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_phase_ready", 32'(phase_ready), 1);
        check("bp_release_valid", 32'(pitch_valid), 0);
        check("bp_release_count", 32'(n_out), 7);

        pitch_ready = 1'b0;
        send_fbin(10);
        send_frame(24'h000000, 1023);
        wait_valid("rst_out_valid");
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(pitch_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_out_data", 32'(pitch_data), 0);
        check("rst_mid_out_phase_ready", 32'(phase_ready), 1);
        pitch_ready = 1'b1;
        send_fbin(10);
        send_frame(24'h000000, 1023);
        settle();
        check("rst_mid_out_first_again", 32'(n_out), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_vocoder_pitch.md
# phase_vocoder_pitch

Parametrised phase-vocoder pitch estimator. It consumes the per-bin CORDIC phase stream of each FFT frame and the fundamental-bin index from the bin finder. It keeps the low NUM_BINS phases of the current and previous frame in a ping-pong store. From the wrapped phase advance of the fundamental bin it computes a refined frequency in Hz, and emits it on a backpressured stream.

## Interface
- FFT_N, 1024: FFT size; power of 2.
- HOP, 1024: frame hop in samples; power of 2, ≤ FFT_N.
- FS, 48000: sample rate in Hz.
- NUM_BINS, 32: bins stored per frame; power of 2, ≤ FFT_N.
- PHASE_W, 24: phase width, signed 3.(PHASE_W-3) scaled radians (1.0 = π).
- OUT_W, 24: pitch width, unsigned Q(OUT_W-10).10 Hz.
- clk in 1: clock.
- reset in 1: reset, synchronous, active-high.
- phase_data in PHASE_W: bin phase, bins arrive in order 0..FFT_N-1.
- phase_valid in 1 / phase_ready out 1: phase handshake.
- phase_last in 1: marks bin FFT_N-1.
- fbin_data in $clog2(NUM_BINS)+1: fundamental bin index k.
- fbin_valid in 1 / fbin_ready out 1: bin handshake; one bin per frame.
- pitch_data out OUT_W: frequency estimate.
- pitch_valid out 1 / pitch_ready in 1: output handshake.
- frame_err out 1: one-cycle pulse when a frame is malformed.
- bin_err out 1: one-cycle pulse when k ≥ NUM_BINS.

## Operation
- States: FILL, WAIT_BIN, READ, DELTA, SCALE, SUM, OUT.
- FILL:
  - phase_ready=1.
  - Bin counter b increments on each phase handshake.
  - Writes phase to bank sel at address b while b < NUM_BINS; higher bins are discarded.
- fbin handshake is accepted in FILL or WAIT_BIN when the 1-entry holding register is empty; fbin_ready=0 otherwise.
- Frame end (handshake with phase_last):
  - b must equal FFT_N-1. If it does not, pulse frame_err, clear b, discard the held bin, set first=1, and stay in FILL.
  - Otherwise go to WAIT_BIN, or straight to READ if a bin is already held.
- A phase handshake where b = FFT_N-1 without phase_last is also treated as frame_err.
- WAIT_BIN: phase_ready=0; go to READ on fbin handshake.
- READ dispatch:
  - first=1 (no previous frame): no output; clear first, flip sel, go to FILL.
  - k ≥ NUM_BINS: pulse bin_err, flip sel, go to FILL.
  - Otherwise do a registered read of both banks at k.
- DELTA:
  - d = cur − last.
  - Subtract expected advance e = (k·2·HOP/FFT_N) mod 2.
  - Wrap to [-1,1) by keeping PHASE_W-2 LSBs and sign-extending; call the result dev.
- SCALE:
  - bin_hz = k·BIN_HZ, where BIN_HZ = round(FS·1024/FFT_N).
  - corr = (dev·CORR_HZ) >>> (PHASE_W-3), where CORR_HZ = round(FS·1024/(2·HOP)).
  - Both are full-precision products.
- SUM: f = bin_hz + corr; clamp negatives to 0 and overflow to 2^OUT_W−1; register into pitch_data.
- OUT: pitch_valid=1 and data held stable until pitch_ready; then flip sel, clear b and the held bin, go to FILL.
- phase_ready=0 in all states except FILL. Phase input stalls until the result is consumed, so neither bank is overwritten before it is read.

## Timing
- Reset values:
  - Outputs: pitch_valid=0, pitch_data=0, frame_err=0, bin_err=0, phase_ready=0, fbin_ready=0.
  - Internal: state=FILL, first=1, sel=0, b=0, held bin empty.
  - phase_ready and fbin_ready go to 1 on the first cycle after reset deasserts.
- Latency: pitch_valid asserts 4 cycles after entering READ (READ→DELTA→SCALE→SUM→OUT).
- READ is entered the cycle after the later of the phase_last handshake and the fbin handshake.
- Simultaneous phase_last and fbin handshakes are both accepted; the next state is READ.
- A pitch_ready already high in the first OUT cycle completes the transfer in that cycle.
- Reset mid-frame or mid-OUT discards all state and drops pitch_valid immediately.

## Structure
- Shared package pitch_pkg: state enum, phase fixed-point constants (PHASE_FRAC = PHASE_W-3), and BIN_HZ/CORR_HZ derivation functions.
- Sub-module phase_pingpong_ram:
  - Two NUM_BINS×PHASE_W banks.
  - One write port with bank select.
  - Dual registered read of both banks at one address.

## Test plan
Defaults apply: 1.0 = 0x200000, BIN_HZ=48000, CORR_HZ=24000.
- Two frames, all phases 0, k=10 → one output, pitch_data=0x075300 (468.75 Hz); none after frame 1.
- Frame 1 bin10=0x000000, frame 2 bin10=0x100000 (+0.5π), k=10 → 0x0781E0 (480.47 Hz).
- Wrap: last=0x1C0000, cur=0xE40000 (d=−1.75 → dev=+0.25), k=10 → 0x076A70 (474.61 Hz).
- k=40 → bin_err pulses once, no pitch_valid; the next frame with k=10 still produces an output (that frame becomes the new previous).
- phase_last at b=500 → frame_err pulse; the next two good frames yield exactly one output.
- Backpressure: pitch_ready low 10 cycles → pitch_data stable, phase_ready=0 throughout; handshake on cycle 11 → phase_ready=1 next cycle.
